mem_grant_arbiter: RTL and testbench
====================================

Name: mem_grant_arbiter

Overview:
Responder side of the shared-memory grant handshake used by the coprocessor main control unit and the p processing elements. It accepts grant requests and issues a one-hot grant using round-robin priority. It routes the granted requester's address, write data and write enable to the single memory port, and broadcasts read data. A hold-limit counter revokes a grant that is held too long, so one client cannot starve the others.

Parameters:
N_REQ, 5, number of requesters (index 0 = main control unit, 1..N_REQ-1 = processors)
ADDR_W, 16, memory address width
DATA_W, 32, memory data width
MAX_HOLD, 64, maximum consecutive cycles one grant may be held (>=2)

Ports:
i_Clock  input  1  system clock, rising edge
i_Reset_n  input  1  asynchronous active-low reset
i_Grant_Request  input  N_REQ  per-requester request, level, held until done
i_Req_Address  input  N_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
i_Req_Write_Data  input  N_REQ*DATA_W  packed write data, same packing
i_Req_Write_Enable  input  N_REQ  per-requester write strobe
i_Mem_Read_Data  input  DATA_W  memory read data (combinational read)
o_Grant  output  N_REQ  one-hot grant, registered
o_Mem_Address  output  ADDR_W  address to memory
o_Mem_Write_Data  output  DATA_W  write data to memory
o_Mem_Write_Enable  output  1  memory write strobe
o_Read_Data  output  DATA_W  i_Mem_Read_Data broadcast to all requesters
o_Hold_Timeout  output  1  one-cycle pulse when a grant is force-revoked
o_Busy  output  1  high while any grant is active

Behaviour:
- Reset, asynchronous, i_Reset_n=0:
  - o_Grant=0, o_Hold_Timeout=0, o_Busy=0.
  - Round-robin pointer=0, hold counter=0, state=S_IDLE.
  - Memory outputs: o_Mem_Address=0, o_Mem_Write_Data=0, o_Mem_Write_Enable=0.
- States: S_IDLE, S_GRANTED, S_RELEASE.
- S_IDLE:
  - If any i_Grant_Request bit is set, pick the first set bit searching upward from the pointer, wrapping modulo N_REQ.
  - Next edge: o_Grant = that bit, counter = 1, go to S_GRANTED.
  - Grant latency is 1 cycle from request seen high.
- S_GRANTED, owner k:
  - o_Mem_* reflect requester k combinationally from the registered grant.
  - o_Mem_Write_Enable = i_Req_Write_Enable[k] AND o_Grant[k].
  - Writes by non-granted requesters are ignored.
- Release: i_Grant_Request[k] low on a rising edge causes:
  - o_Grant=0 on that edge.
  - pointer = (k+1) mod N_REQ.
  - go to S_RELEASE.
- Timeout: counter reaches MAX_HOLD while the request is still high causes:
  - o_Grant=0, o_Hold_Timeout=1 for exactly one cycle.
  - pointer = (k+1) mod N_REQ, go to S_RELEASE.
  - The timed-out requester must drop and re-raise its request; a still-high request is not re-granted until a 0 has been seen on it.
- Counter saturates and never wraps.
- S_RELEASE:
  - Exactly one idle turnaround cycle; o_Grant=0 and o_Mem_Write_Enable=0.
  - Then S_IDLE; arbitration happens in S_IDLE on the next cycle.
  - Back-to-back grants are therefore separated by 2 cycles of no grant.
- Fairness:
  - Simultaneous requests are resolved only by the pointer.
  - After owner k releases, k has lowest priority.
  - With all N_REQ requesting continuously, each is granted once per N_REQ grants.
- Request raised and dropped within S_RELEASE: not granted; no state is kept per pulse.
- o_Busy = |o_Grant.
- o_Read_Data = i_Mem_Read_Data always; requesters qualify it with their own grant.
- Reset mid-grant: grant drops immediately (asynchronous); no memory write may occur on the reset edge.

Test Plan:
- Reset, then i_Grant_Request=5'b00100 -> o_Grant=5'b00100 one cycle later; o_Mem_Address equals requester 2's address; o_Busy=1.
- Requests 5'b10011 held continuously, pointer=0 -> grants in order 0,1,4,0 as each releases; 2 no-grant cycles between each grant.
- Owner 1 holds request for 70 cycles, MAX_HOLD=64 -> grant drops after cycle 64 with o_Hold_Timeout pulse of 1 cycle; requester 1 is not regranted while its request is still high.
- Requester 3 asserts i_Req_Write_Enable without a grant while 0 owns the port -> o_Mem_Write_Enable follows only requester 0's strobe; memory contents for 3's address are unchanged.
- Assert i_Reset_n=0 mid-grant with write enable high -> o_Grant=0 and o_Mem_Write_Enable=0 asynchronously; after release, first grant goes to lowest set index from pointer 0.
- N_REQ=2, requests alternate each release -> strict alternation 0,1,0,1; pointer wraps 1->0 correctly.

Source files
------------

// File: rtl/mem_grant_arbiter.sv
// mem_grant_arbiter: round-robin owner of the single shared memory port.
// Requesters raise a level request and keep it high for as long as they
// need the port. The arbiter answers with a registered one-hot grant. While
// the grant is held, the owner's address, write data and write strobe are
// steered to memory. A hold counter force-revokes a grant that has been held
// for MAX_HOLD cycles. A revoked requester is then locked out until its
// request has been seen low at least once.
//
// Handshake: a requester owns the port in every cycle where o_Grant[k] is
// high. It releases the port by dropping i_Grant_Request[k]; the grant falls
// on the first rising edge that samples the request low. Between two
// consecutive grants there are always exactly two cycles with no grant:
// one turnaround cycle, then one arbitration cycle.

module mem_grant_arbiter #(
  parameter int N_REQ    = 5,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic [N_REQ-1:0]          i_Grant_Request,
  input  logic [N_REQ*ADDR_W-1:0]   i_Req_Address,
  input  logic [N_REQ*DATA_W-1:0]   i_Req_Write_Data,
  input  logic [N_REQ-1:0]          i_Req_Write_Enable,
  input  logic [DATA_W-1:0]         i_Mem_Read_Data,
  output logic [N_REQ-1:0]          o_Grant,
  output logic [ADDR_W-1:0]         o_Mem_Address,
  output logic [DATA_W-1:0]         o_Mem_Write_Data,
  output logic                      o_Mem_Write_Enable,
  output logic [DATA_W-1:0]         o_Read_Data,
  output logic                      o_Hold_Timeout,
  output logic                      o_Busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  localparam logic [PTR_W:0]   N_WIDE    = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // FSM state (kept as a named enum so it is visible by name in waveforms)
  state_t state;
  state_t state_next;

  // Registered datapath and its next values
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] grant_next;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_next;
  logic             timeout;
  logic             timeout_next;
  logic [N_REQ-1:0] locked;
  logic [N_REQ-1:0] locked_next;

  // Arbitration helpers
  logic [N_REQ-1:0] eligible;
  logic             any_eligible;
  logic [N_REQ-1:0] elig_rot;
  logic [PTR_W-1:0] first_off;
  logic [PTR_W:0]   pick_sum;
  logic [PTR_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  // Current-owner helpers
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] owner_succ;
  logic             owner_req;
  logic             hold_expired;

  // A locked-out requester takes no part in arbitration until it drops.
  assign eligible     = i_Grant_Request & ~locked;
  assign any_eligible = |eligible;

  // Round-robin pick: rotate so that bit 0 is the pointer, then take the
  // lowest set bit and map its offset back to an absolute index.
  always_comb begin
    elig_rot  = N_REQ'({eligible, eligible} >> ptr);
    first_off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (elig_rot[j]) begin
        first_off = PTR_W'(j);
      end
    end
    pick_sum = {1'b0, ptr} + {1'b0, first_off};
    if (pick_sum >= N_WIDE) begin
      pick_idx = PTR_W'(pick_sum - N_WIDE);
    end else begin
      pick_idx = PTR_W'(pick_sum);
    end
    pick_onehot = N_REQ'(1) << pick_idx;
  end

  // Decode the current owner from the one-hot grant.
  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        owner_idx = PTR_W'(k);
      end
    end
    owner_succ   = (owner_idx == LAST_IDX) ? '0 : owner_idx + PTR_W'(1);
    owner_req    = |(grant & i_Grant_Request);
    hold_expired = (hold_cnt == HOLD_MAX);
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (any_eligible) begin
          state_next = S_GRANTED;
        end
      end
      S_GRANTED: begin
        if (!owner_req || hold_expired) begin
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Next values of the grant, pointer, hold counter, timeout and lockouts.
  always_comb begin
    grant_next    = grant;
    ptr_next      = ptr;
    hold_cnt_next = hold_cnt;
    timeout_next  = 1'b0;
    // A lockout clears as soon as the request is seen low.
    locked_next   = locked & i_Grant_Request;
    case (state)
      S_IDLE: begin
        if (any_eligible) begin
          grant_next    = pick_onehot;
          hold_cnt_next = HOLD_ONE;
        end else begin
          grant_next    = '0;
        end
      end
      S_GRANTED: begin
        if (!owner_req) begin
          grant_next    = '0;
          ptr_next      = owner_succ;
          hold_cnt_next = '0;
        end else if (hold_expired) begin
          grant_next    = '0;
          ptr_next      = owner_succ;
          hold_cnt_next = '0;
          timeout_next  = 1'b1;
          locked_next   = locked_next | grant;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_next = hold_cnt + HOLD_ONE;
        end
      end
      S_RELEASE: begin
        grant_next = '0;
      end
      default: begin
        grant_next = '0;
      end
    endcase
  end

  // Datapath registers; reset clears the grant asynchronously, which
  // immediately kills the memory strobe.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      grant    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
      locked   <= '0;
    end else begin
      grant    <= grant_next;
      ptr      <= ptr_next;
      hold_cnt <= hold_cnt_next;
      timeout  <= timeout_next;
      locked   <= locked_next;
    end
  end

  // Steer the owner's address, data and strobe to memory; zero when idle.
  always_comb begin
    o_Mem_Address      = '0;
    o_Mem_Write_Data   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        o_Mem_Address    = i_Req_Address[k*ADDR_W +: ADDR_W];
        o_Mem_Write_Data = i_Req_Write_Data[k*DATA_W +: DATA_W];
      end
    end
    o_Mem_Write_Enable = |(grant & i_Req_Write_Enable);
  end

  assign o_Grant        = grant;
  assign o_Hold_Timeout = timeout;
  assign o_Busy         = |grant;
  assign o_Read_Data    = i_Mem_Read_Data;

endmodule

// File: tb/tb_mem_grant_arbiter.sv
// Bench for mem_grant_arbiter: directed scenarios with hand-computed results,
// then random request traffic, all checked every cycle against a
// transaction-level model of owner / pointer / lockout behaviour.

module tb_mem_grant_arbiter;

  localparam int N  = 5;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MH = 64;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [N-1:0]    req       = '0;
  logic [N*AW-1:0] addr_bus  = '0;
  logic [N*DW-1:0] wdata_bus = '0;
  logic [N-1:0]    we        = '0;
  logic [DW-1:0]   mem_rd;
  logic [N-1:0]    grant;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic [DW-1:0]   rd_data;
  logic            hold_to;
  logic            busy;

  mem_grant_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .i_Clock            (clk),
    .i_Reset_n          (rst_n),
    .i_Grant_Request    (req),
    .i_Req_Address      (addr_bus),
    .i_Req_Write_Data   (wdata_bus),
    .i_Req_Write_Enable (we),
    .i_Mem_Read_Data    (mem_rd),
    .o_Grant            (grant),
    .o_Mem_Address      (mem_addr),
    .o_Mem_Write_Data   (mem_wdata),
    .o_Mem_Write_Enable (mem_we),
    .o_Read_Data        (rd_data),
    .o_Hold_Timeout     (hold_to),
    .o_Busy             (busy)
  );

  // ---------------- memory (environment) ----------------
  logic [DW-1:0] mem [256];
  logic [DW-1:0] exp_mem [256];

  function automatic logic [DW-1:0] mem_init(input int a);
    return (DW'(a) * 32'h0101_0101) ^ 32'h0000_00A5;
  endfunction

  assign mem_rd = mem[mem_addr[7:0]];

  // Memory is reloaded with its known pattern whenever reset is asserted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int k);
    return addr_bus[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int k);
    return wdata_bus[k*DW +: DW];
  endfunction

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  // owner: -1 when nobody holds the port. cool: cycles that must still pass
  // before arbitration may look at requests again.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_cool  = 0;
  bit m_to    = 1'b0;
  bit m_lock [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_cool  = 0;
      m_to    = 1'b0;
      for (int k = 0; k < N; k++) m_lock[k] = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = mem_init(i);
    end else begin
      logic [AW-1:0] a;
      bit found;
      if (m_owner >= 0 && we[m_owner]) begin
        a = addr_of(m_owner);
        exp_mem[a[7:0]] = wdata_of(m_owner);
      end
      m_to = 1'b0;
      for (int k = 0; k < N; k++) if (!req[k]) m_lock[k] = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_cool  = 1;
        end else if (m_held == MH) begin
          m_to           = 1'b1;
          m_lock[m_owner] = 1'b1;
          m_ptr          = (m_owner + 1) % N;
          m_owner        = -1;
          m_cool         = 1;
        end else begin
          m_held++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_ptr + i) % N;
          if (!found && req[c] && !m_lock[c]) begin
            found   = 1'b1;
            m_owner = c;
            m_held  = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [N-1:0]  e_grant;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_we;
    e_grant = '0;
    e_addr  = '0;
    e_wdata = '0;
    e_we    = 1'b0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_addr  = addr_of(m_owner);
      e_wdata = wdata_of(m_owner);
      e_we    = we[m_owner];
    end
    check("grant",     64'(grant),     64'(e_grant));
    check("mem_addr",  64'(mem_addr),  64'(e_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    check("mem_we",    64'(mem_we),    64'(e_we));
    check("timeout",   64'(hold_to),   64'(m_to));
    check("busy",      64'(busy),      64'(m_owner >= 0));
    check("read_data", 64'(rd_data),   64'(mem_rd));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    we  = '0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Hold pattern pat; each owner drops its bit after hold_n granted cycles
  // and raises it again once the grant is gone. Records grant order and the
  // number of no-grant cycles preceding each grant.
  int rr_order [4];
  int rr_gap   [4];
  int rr_got;

  task automatic rr_run(input logic [N-1:0] pat, input int hold_n);
    int held;
    int gap;
    logic [N-1:0] prev;
    held   = 0;
    gap    = 0;
    prev   = '0;
    rr_got = 0;
    for (int i = 0; i < 4; i++) begin
      rr_order[i] = -1;
      rr_gap[i]   = -1;
    end
    req = pat;
    for (int c = 0; c < 100 && rr_got < 4; c++) begin
      step();
      if (grant != '0) begin
        if (prev == '0) begin
          rr_order[rr_got] = first_set(grant);
          rr_gap[rr_got]   = gap;
          rr_got++;
          held = 0;
        end
        held++;
        if (held == hold_n) req = pat & ~grant;
        gap = 0;
      end else begin
        gap++;
        req = pat;
      end
      prev = grant;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g_cyc;
    int to_cyc;
    int rises;
    logic [N-1:0] prev;

    for (int k = 0; k < N; k++) begin
      addr_bus[k*AW +: AW]  = AW'(16'h0010 + k);
      wdata_bus[k*DW +: DW] = DW'(32'hC0DE_0000 + k);
    end

    // Reset state
    repeat (3) step();
    check("rst_grant", 64'(grant),    64'h0);
    check("rst_busy",  64'(busy),     64'h0);
    check("rst_addr",  64'(mem_addr), 64'h0);
    check("rst_we",    64'(mem_we),   64'h0);
    rst_n = 1'b1;
    step();

    // Single request: granted one cycle later
    req = 5'b00100;
    step();
    check("single_grant", 64'(grant),    64'h04);
    check("single_addr",  64'(mem_addr), 64'h0012);
    check("single_busy",  64'(busy),     64'h1);
    idle(4);

    // Round robin from pointer 0 over requesters 0,1,4
    do_reset();
    rr_run(5'b10011, 3);
    check("rr_count", 64'(rr_got), 64'd4);
    check("rr_g0", 64'(rr_order[0]), 64'd0);
    check("rr_g1", 64'(rr_order[1]), 64'd1);
    check("rr_g2", 64'(rr_order[2]), 64'd4);
    check("rr_g3", 64'(rr_order[3]), 64'd0);
    for (int i = 1; i < 4; i++) check("rr_gap", 64'(rr_gap[i]), 64'd2);
    idle(4);

    // Hold-limit timeout on requester 1
    req    = 5'b00010;
    g_cyc  = 0;
    to_cyc = 0;
    rises  = 0;
    prev   = '0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (grant[1]) g_cyc++;
      if (hold_to) to_cyc++;
      if (grant[1] && !prev[1]) rises++;
      prev = grant;
    end
    check("to_held_cycles", 64'(g_cyc),  64'd64);
    check("to_pulses",      64'(to_cyc), 64'd1);
    check("to_no_regrant",  64'(rises),  64'd1);
    req = '0;
    step();
    step();
    req = 5'b00010;
    step();
    check("to_regrant", 64'(grant), 64'h02);
    idle(4);

    // Non-granted writer is ignored
    addr_bus[0*AW +: AW]  = 16'h0040;
    addr_bus[3*AW +: AW]  = 16'h0050;
    wdata_bus[0*DW +: DW] = 32'h1111_0000;
    wdata_bus[3*DW +: DW] = 32'hDEAD_BEEF;
    req = 5'b00001;
    we  = 5'b01000;
    step();
    check("iso_grant", 64'(grant), 64'h01);
    for (int c = 0; c < 6; c++) begin
      we = 5'b01000 | 5'(c % 2);
      #1;
      check("iso_we", 64'(mem_we), 64'(c % 2));
      step();
    end
    idle(3);
    check("iso_mem3", 64'(mem[8'h50]), 64'(mem_init(8'h50)));
    check("iso_mem0", 64'(mem[8'h40]), 64'h1111_0000);

    // Asynchronous reset in the middle of a writing grant
    req = 5'b00100;
    we  = 5'b00100;
    step();
    step();
    check("mid_grant_before", 64'(grant), 64'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 64'(grant),  64'h0);
    check("mid_rst_we",    64'(mem_we), 64'h0);
    check("mid_rst_busy",  64'(busy),   64'h0);
    step();
    req = '0;
    we  = '0;
    step();
    rst_n = 1'b1;
    step();
    req = 5'b10100;
    step();
    check("post_rst_grant", 64'(grant), 64'h04);
    idle(4);

    // Two requesters strictly alternate
    do_reset();
    rr_run(5'b00011, 2);
    check("alt_count", 64'(rr_got), 64'd4);
    check("alt_g0", 64'(rr_order[0]), 64'd0);
    check("alt_g1", 64'(rr_order[1]), 64'd1);
    check("alt_g2", 64'(rr_order[2]), 64'd0);
    check("alt_g3", 64'(rr_order[3]), 64'd1);
    idle(4);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 29) == 0) req[k] = ~req[k];
        addr_bus[k*AW +: AW]  = {8'h00, 8'($urandom)};
        wdata_bus[k*DW +: DW] = $urandom;
      end
      we = N'($urandom);
      step();
    end
    idle(5);

    for (int i = 0; i < 256; i++) check("mem_contents", 64'(mem[i]), 64'(exp_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
